// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output scheduler.
// Holds the default widths, the FSM state type and the packed-slice extractor.
package audio_pkg;

   localparam int SAMPLE_W_DEF    = 16;
   localparam int FRAME_DIV_W_DEF = 9;
   localparam int MAX_REQ         = 8;
   localparam int MAX_SAMPLE_W    = 32;
   localparam int SLICE_BUS_W     = MAX_REQ * MAX_SAMPLE_W;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   // Returns slice idx of a bus packed as width-bit fields (width <= MAX_SAMPLE_W).
   function automatic logic [MAX_SAMPLE_W-1:0] slice_of(
      input logic [SLICE_BUS_W-1:0] bus,
      input int unsigned            idx,
      input int unsigned            width
   );
      logic [SLICE_BUS_W-1:0]  shifted;
      logic [MAX_SAMPLE_W-1:0] mask;
      shifted = bus >> (idx * width);
      mask    = {MAX_SAMPLE_W{1'b1}} >> (MAX_SAMPLE_W - width);
      return shifted[MAX_SAMPLE_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/audio_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NUM_REQ.
module audio_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int               sum;
      logic [IDX_W-1:0] cand;
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      sum  = 0;
      cand = '0;
      idx  = '0;
      any  = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = int'(ptr) + off;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         cand = IDX_W'(sum);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      onehot = any ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/audio_output_scheduler.sv
// Shares one I2S speaker path among NUM_REQ sources: frame-locked round-robin ownership
// and a once-per-frame latch of the owner's stereo sample.
module audio_output_scheduler
   import audio_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int SAMPLE_W    = SAMPLE_W_DEF,
   parameter int FRAME_DIV_W = FRAME_DIV_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          smp_valid,
   input  logic [NUM_REQ*SAMPLE_W-1:0] smp_left,
   input  logic [NUM_REQ*SAMPLE_W-1:0] smp_right,
   input  logic                        mute,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          smp_ack,
   output logic                        frame_tick,
   output logic                        underrun,
   output logic [SAMPLE_W-1:0]         audio_left,
   output logic [SAMPLE_W-1:0]         audio_right
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [FRAME_DIV_W-1:0] PRE_LAST = {{(FRAME_DIV_W-1){1'b1}}, 1'b0};

   logic [FRAME_DIV_W-1:0] cnt;
   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [NUM_REQ-1:0]     win_onehot;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_any;
   logic                   latch_en, clear_en, ack_en, under_en;
   logic [SAMPLE_W-1:0]    owner_left, owner_right;

   // Tick is registered one count early so it coincides with cnt == max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         frame_tick <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         cnt        <= cnt + 1'b1;
         frame_tick <= (cnt == PRE_LAST);
      end
   end

   audio_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (win_onehot),
      .idx    (win_idx),
      .any    (win_any)
   );

   assign owner_left  = SAMPLE_W'(slice_of(SLICE_BUS_W'(smp_left),  32'(owner_q), SAMPLE_W));
   assign owner_right = SAMPLE_W'(slice_of(SLICE_BUS_W'(smp_right), 32'(owner_q), SAMPLE_W));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state: all decisions are taken only on the frame_tick cycle.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      latch_en = 1'b0;
      clear_en = 1'b0;
      ack_en   = 1'b0;
      under_en = 1'b0;
      if (frame_tick) begin
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  state_d = OWNED;
                  owner_d = win_idx;
                  ptr_d   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
               end
            end
            OWNED: begin
               if (req[owner_q]) begin
                  if (smp_valid[owner_q]) begin
                     latch_en = 1'b1;
                     ack_en   = 1'b1;
                  end else begin
                     clear_en = 1'b1;
                     under_en = 1'b1;
                  end
               end else begin
                  // Release: ptr already points past the old owner, so it ranks last.
                  clear_en = 1'b1;
                  if (win_any) begin
                     owner_d = win_idx;
                     ptr_d   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs decoded from state.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant[i] = (state_q == OWNED) && (owner_q == IDX_W'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_ack     <= '0;
         underrun    <= 1'b0;
         audio_left  <= '0;
         audio_right <= '0;
      end else begin
         smp_ack  <= ack_en ? grant : '0;
         underrun <= under_en;
         if (latch_en) begin
            audio_left  <= mute ? '0 : owner_left;
            audio_right <= mute ? '0 : owner_right;
         end else if (clear_en) begin
            audio_left  <= '0;
            audio_right <= '0;
         end
      end
   end

   logic unused_onehot;
   assign unused_onehot = ^win_onehot;

endmodule
